udma_extper_rx_arbiter: RTL and testbench
=========================================

Name: udma_extper_rx_arbiter

Overview:
- Shares the single 32-bit external-peripheral RX path to L2 among NB_CH requesters.
- Each requester is a serializer output: a 64-bit word split into two 32-bit beats.
- Round-robin arbitration with a grant lock, so both halves of a 64-bit word stay contiguous.
- Per-channel transfer-length counters sequence each channel's job and flag completion.

Parameters:
- NB_CH, 4, number of requester channels (2..8).
- TRANS_SIZE, 16, width of the per-channel beat-length counter.
- BEATS_PER_GRANT, 2, beats a channel keeps the grant once selected (1..8).

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start_i  in  NB_CH  per-channel start pulse; loads cfg_len_i.
- cfg_len_i  in  NB_CH*TRANS_SIZE  beats to transfer per channel.
- cfg_clr_i  in  NB_CH  per-channel abort pulse.
- ch_rdata_i  in  NB_CH*32  requester data.
- ch_valid_i  in  NB_CH  requester valid.
- ch_ready_o  out  NB_CH  requester ready.
- data_rx_rdata_o  out  32  data to L2.
- data_rx_valid_o  out  1  valid to L2.
- data_rx_ready_i  in  1  ready from L2.
- data_rx_chan_o  out  $clog2(NB_CH)  id of the channel owning the current beat.
- ch_busy_o  out  NB_CH  channel active (remaining count > 0).
- ch_done_o  out  NB_CH  one-cycle pulse when a channel's count reaches 0.
- ch_stall_cnt_o  out  NB_CH*16  stall statistics (see Optional Feature).

Behaviour:
- Reset values: all outputs 0. FSM = ARB_IDLE, rr_ptr = 0, all counters 0, lock counter 0.
- Start:
  - cfg_start_i[k] with ch_busy_o[k]=0 loads remain[k]=cfg_len_i[k]; busy rises next cycle.
  - Start while busy is ignored.
  - cfg_len=0 gives no load; ch_done_o[k] pulses the next cycle.
- Eligibility: req[k] = ch_busy_o[k] & ch_valid_i[k].
- FSM:
  - ARB_IDLE: if any req, pick the first requester at or after rr_ptr (wrapping). Register sel and lock_cnt=0, go to ARB_LOCK. Outputs are idle during this cycle, giving a 1-cycle bubble per grant.
  - ARB_LOCK: data_rx_rdata_o = ch_rdata_i[sel]; data_rx_valid_o = ch_valid_i[sel]; ch_ready_o[sel] = data_rx_ready_i; all other ch_ready_o are 0. These paths are combinational, with zero latency.
  - Beat accepted (valid & ready): remain[sel]-1, lock_cnt+1.
  - Leave ARB_LOCK for ARB_IDLE when any of these holds:
    - lock_cnt reaches BEATS_PER_GRANT on an accepted beat;
    - remain[sel] reaches 0;
    - cfg_clr_i[sel] is asserted.
  - On leaving ARB_LOCK, rr_ptr = sel+1 mod NB_CH.
  - If ch_valid_i[sel] drops while locked, the lock holds and waits, with no re-arbitration.
- Done: an accepted beat taking remain 1→0 pulses ch_done_o[sel] in the following cycle. Busy clears the same cycle as the pulse.
- Clear (cfg_clr_i[k]):
  - remain[k]=0 next cycle; no done pulse.
  - If k is locked, a beat accepted in that same cycle still completes to L2 but is not counted; the grant is released.
- Simultaneous cfg_start_i and cfg_clr_i on one channel: clear wins.
- Counter width: remain is TRANS_SIZE bits and never underflows; beats are accepted only while remain>0.
- data_rx_chan_o = sel while in ARB_LOCK, else 0.

Optional Feature:
- Macro: UDMA_RX_ARB_STATS_EN.
- Defined: per-channel 16-bit saturating counter increments each cycle the channel is locked with data_rx_valid_o=1 and data_rx_ready_i=0. Cleared by the channel's cfg_clr_i or cfg_start_i; driven on ch_stall_cnt_o.
- Undefined: no counters; ch_stall_cnt_o tied to 0.

Decomposition:
- Package udma_rx_arb_pkg holds:
  - enum arb_state_e {ARB_IDLE, ARB_LOCK};
  - localparam STALL_W=16;
  - function ch_id_w(NB_CH).
- Sub-module udma_rx_arb_rr_pick: combinational round-robin picker. Inputs are the NB_CH request vector and rr_ptr; outputs are the gnt_id and gnt_valid.

Test Plan:
- Single channel, len=4, ready=1 → ch0 beats D0,D1 after 1 bubble, then idle cycle, then D2,D3; ch_done_o[0] pulses once; chan_o=0 throughout.
- Ch0 and ch2 started with len=4, both always valid → beat order ch0,ch0,ch2,ch2,ch0,ch0,ch2,ch2; both done pulses.
- Ready low 3 cycles mid-pair on ch1 → ch1 keeps the grant, no beat lost or duplicated; with STATS_EN, ch_stall_cnt[1]=3.
- Clear ch0 after 1 of 6 beats while locked → grant released, busy[0]=0 next cycle, no done pulse, ch1 then served.
- Start ch3 with len=0 → done[3] pulses next cycle, no grant issued; start during busy ch3 (len=8 running) → ignored, remain unchanged.
- rst_n asserted mid-lock → all outputs 0 immediately, FSM ARB_IDLE, rr_ptr 0 after release.

Source files
------------

// File: rtl/udma_rx_arb_pkg.sv
// Shared types and helpers for the external-peripheral RX arbiter.
// The optional stall statistics are enabled with the UDMA_RX_ARB_STATS_EN macro.
package udma_rx_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int STALL_W = 16;

  // Width of a channel index. It never drops below 1 bit, so a single-channel build still has a legal vector.
  function automatic int ch_id_w(input int nb_ch);
    return (nb_ch > 1) ? $clog2(nb_ch) : 1;
  endfunction

endpackage

// File: rtl/udma_rx_arb_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester found at or after rr_ptr, wrapping past the last channel.
module udma_rx_arb_rr_pick
  import udma_rx_arb_pkg::*;
#(
  parameter int NB_CH = 4,
  parameter int ID_W  = ch_id_w(NB_CH)
) (
  input  logic [NB_CH-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // NOTE: every signal driven here is given a default value first, so no path through the loop can infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NB_CH; i++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NB_CH)) sum = sum - (ID_W+1)'(NB_CH);
      idx = sum[ID_W-1:0];
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/udma_extper_rx_arbiter.sv
// Shares one 32-bit RX path to L2 among NB_CH serializer channels. It uses round-robin arbitration with a grant lock.
// The optional per-channel stall counters are enabled with UDMA_RX_ARB_STATS_EN.
module udma_extper_rx_arbiter
  import udma_rx_arb_pkg::*;
#(
  parameter int NB_CH           = 4,
  parameter int TRANS_SIZE      = 16,
  parameter int BEATS_PER_GRANT = 2
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic [NB_CH-1:0]            cfg_start_i,
  input  logic [NB_CH*TRANS_SIZE-1:0] cfg_len_i,
  input  logic [NB_CH-1:0]            cfg_clr_i,
  input  logic [NB_CH*32-1:0]         ch_rdata_i,
  input  logic [NB_CH-1:0]            ch_valid_i,
  output logic [NB_CH-1:0]            ch_ready_o,
  output logic [31:0]                 data_rx_rdata_o,
  output logic                        data_rx_valid_o,
  input  logic                        data_rx_ready_i,
  output logic [$clog2(NB_CH)-1:0]    data_rx_chan_o,
  output logic [NB_CH-1:0]            ch_busy_o,
  output logic [NB_CH-1:0]            ch_done_o,
  output logic [NB_CH*STALL_W-1:0]    ch_stall_cnt_o
);

  localparam int ID_W   = ch_id_w(NB_CH);
  localparam int LOCK_W = $clog2(BEATS_PER_GRANT + 1);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     sel_q, sel_d, rr_ptr_q, rr_ptr_d, gnt_id;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                gnt_valid, beat_acc, sel_busy;
  logic [NB_CH-1:0]    req, cnt_dec, done_d, done_q;
  logic [TRANS_SIZE-1:0] remain_q [NB_CH];
  logic [TRANS_SIZE-1:0] len_a    [NB_CH];
  logic [31:0]           rdata_a  [NB_CH];

  for (genvar k = 0; k < NB_CH; k++) begin : g_ch
    assign len_a[k]     = cfg_len_i[k*TRANS_SIZE +: TRANS_SIZE];
    assign rdata_a[k]   = ch_rdata_i[k*32 +: 32];
    assign ch_busy_o[k] = |remain_q[k];
  end

  assign req       = ch_busy_o & ch_valid_i;
  assign ch_done_o = done_q;

  udma_rx_arb_rr_pick #(.NB_CH(NB_CH), .ID_W(ID_W)) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    lock_cnt_d      = lock_cnt_q;
    rr_ptr_d        = rr_ptr_q;
    data_rx_rdata_o = '0;
    data_rx_valid_o = 1'b0;
    data_rx_chan_o  = '0;
    ch_ready_o      = '0;
    beat_acc        = 1'b0;
    sel_busy        = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          sel_d      = gnt_id;
          lock_cnt_d = '0;
          state_d    = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        // Gating with busy means a channel whose count is already exhausted can never push an uncounted beat.
        sel_busy          = ch_busy_o[sel_q];
        data_rx_rdata_o   = rdata_a[sel_q];
        data_rx_valid_o   = ch_valid_i[sel_q] & sel_busy;
        ch_ready_o[sel_q] = data_rx_ready_i & sel_busy;
        data_rx_chan_o    = sel_q;
        beat_acc          = data_rx_valid_o & data_rx_ready_i;
        if (beat_acc) lock_cnt_d = lock_cnt_q + 1'b1;
        if (cfg_clr_i[sel_q] || !sel_busy ||
            (beat_acc && ((lock_cnt_q + 1'b1) == LOCK_W'(BEATS_PER_GRANT) ||
                          remain_q[sel_q] == TRANS_SIZE'(1)))) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (sel_q == ID_W'(NB_CH - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    cnt_dec = '0;
    done_d  = '0;
    for (int k = 0; k < NB_CH; k++) begin
      cnt_dec[k] = beat_acc && (sel_q == ID_W'(k)) && !cfg_clr_i[k];
      done_d[k]  = !cfg_clr_i[k] &&
                   ((cfg_start_i[k] && !ch_busy_o[k] && len_a[k] == '0) ||
                    (cnt_dec[k] && remain_q[k] == TRANS_SIZE'(1)));
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      sel_q      <= '0;
      lock_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      lock_cnt_q <= lock_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // NOTE: the remain array is control state and is therefore reset. The data path is purely combinational and stores nothing that would need a reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NB_CH; k++) remain_q[k] <= '0;
      done_q <= '0;
    end else begin
      for (int k = 0; k < NB_CH; k++) begin
        if (cfg_clr_i[k])                         remain_q[k] <= '0;
        else if (cfg_start_i[k] && !ch_busy_o[k]) remain_q[k] <= len_a[k];
        else if (cnt_dec[k])                      remain_q[k] <= remain_q[k] - 1'b1;
      end
      done_q <= done_d;
    end
  end

`ifdef UDMA_RX_ARB_STATS_EN
  logic [STALL_W-1:0] stall_q [NB_CH];
  logic               stall_hit;

  assign stall_hit = (state_q == ARB_LOCK) && data_rx_valid_o && !data_rx_ready_i;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NB_CH; k++) stall_q[k] <= '0;
    end else begin
      for (int k = 0; k < NB_CH; k++) begin
        if (cfg_clr_i[k] || cfg_start_i[k])
          stall_q[k] <= '0;
        else if (stall_hit && sel_q == ID_W'(k) && stall_q[k] != '1)
          stall_q[k] <= stall_q[k] + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NB_CH; k++) begin : g_stall
    assign ch_stall_cnt_o[k*STALL_W +: STALL_W] = stall_q[k];
  end
`else
  assign ch_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_udma_extper_rx_arbiter.sv
// Scoreboard bench for udma_extper_rx_arbiter. Every beat's expected (channel, data) pair is queued when its job is started.
// The queued pair is compared when L2 accepts the beat.
module tb_udma_extper_rx_arbiter;

  localparam int NB_CH = 4;
  localparam int TS    = 16;

  logic                     sys_clk = 1'b0;
  logic                     rst_n;
  logic [NB_CH-1:0]         cfg_start_i, cfg_clr_i, ch_valid_i, ch_ready_o;
  logic [NB_CH*TS-1:0]      cfg_len_i;
  logic [NB_CH*32-1:0]      ch_rdata_i;
  logic [31:0]              data_rx_rdata_o;
  logic                     data_rx_valid_o, data_rx_ready_i;
  logic [1:0]               data_rx_chan_o;
  logic [NB_CH-1:0]         ch_busy_o, ch_done_o;
  logic [NB_CH*16-1:0]      ch_stall_cnt_o;

  udma_extper_rx_arbiter #(.NB_CH(NB_CH), .TRANS_SIZE(TS), .BEATS_PER_GRANT(2)) dut (
    .sys_clk         (sys_clk),
    .rst_n           (rst_n),
    .cfg_start_i     (cfg_start_i),
    .cfg_len_i       (cfg_len_i),
    .cfg_clr_i       (cfg_clr_i),
    .ch_rdata_i      (ch_rdata_i),
    .ch_valid_i      (ch_valid_i),
    .ch_ready_o      (ch_ready_o),
    .data_rx_rdata_o (data_rx_rdata_o),
    .data_rx_valid_o (data_rx_valid_o),
    .data_rx_ready_i (data_rx_ready_i),
    .data_rx_chan_o  (data_rx_chan_o),
    .ch_busy_o       (ch_busy_o),
    .ch_done_o       (ch_done_o),
    .ch_stall_cnt_o  (ch_stall_cnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    done_cyc[$];
  int    seq[NB_CH];
  int    done_cnt[NB_CH];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  logic  adv = 1'b0;
  int    adv_ch = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester model: each channel streams {channel, sequence number}. The sequence advances after each accepted beat.
  always_comb begin
    ch_rdata_i = '0;
    for (int k = 0; k < NB_CH; k++) ch_rdata_i[k*32 +: 32] = {8'(k), 24'(seq[k])};
  end

  always @(posedge sys_clk) begin
    cyc++;
    #1;
    if (adv) begin
      seq[adv_ch]++;
      adv = 1'b0;
    end
  end

  always @(negedge sys_clk) begin : monitor
    beat_t e;
    if (rst_n) begin
      for (int k = 0; k < NB_CH; k++)
        if (ch_done_o[k]) begin
          done_cnt[k]++;
          done_cyc.push_back(cyc);
        end
      if (data_rx_valid_o && data_rx_ready_i) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", 64'({data_rx_chan_o, data_rx_rdata_o}), 64'(e));
        end
        beat_cyc.push_back(cyc);
        adv    = 1'b1;
        adv_ch = int'(data_rx_chan_o);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_beats(input int k, input int first, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.ch   = 2'(k);
      b.data = {8'(k), 24'(first + i)};
      exp_q.push_back(b);
    end
  endtask

  task automatic set_len(input int k, input int len);
    cfg_len_i[k*TS +: TS] = TS'(len);
  endtask

  task automatic pulse_start(input logic [NB_CH-1:0] mask);
    cfg_start_i = mask;
    tick();
    cfg_start_i = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 64'(data_rx_valid_o), 64'd0);
    check({tag, "_rdata"}, 64'(data_rx_rdata_o), 64'd0);
    check({tag, "_chan"},  64'(data_rx_chan_o),  64'd0);
    check({tag, "_ready"}, 64'(ch_ready_o),      64'd0);
    check({tag, "_busy"},  64'(ch_busy_o),       64'd0);
    check({tag, "_done"},  64'(ch_done_o),       64'd0);
    check({tag, "_stall"}, 64'(ch_stall_cnt_o),  64'd0);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    cfg_start_i     = '0;
    cfg_clr_i       = '0;
    cfg_len_i       = '0;
    ch_valid_i      = '0;
    data_rx_ready_i = 1'b0;
    adv             = 1'b0;
    exp_q.delete();
    beat_cyc.delete();
    done_cyc.delete();
    for (int k = 0; k < NB_CH; k++) begin
      seq[k]      = 0;
      done_cnt[k] = 0;
    end
    repeat (2) tick();
    check_outputs_zero("rst");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || ch_busy_o != '0); i++) tick();
    repeat (2) tick();
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"},  64'(ch_busy_o),    64'd0);
  endtask

  int s0;

  initial begin
    // 1: single channel, four beats, two grants
    do_reset();
    data_rx_ready_i = 1'b1;
    ch_valid_i      = 4'b0001;
    push_beats(0, 0, 4);
    set_len(0, 4);
    s0 = cyc;
    pulse_start(4'b0001);
    wait_drain("t1");
    check("t1_done0", 64'(done_cnt[0]), 64'd1);
    check("t1_nbeats", 64'(beat_cyc.size()), 64'd4);
    if (beat_cyc.size() >= 4 && done_cyc.size() >= 1) begin
      check("t1_lat",  64'(beat_cyc[0] - s0),          64'd2);
      check("t1_gap1", 64'(beat_cyc[1] - beat_cyc[0]), 64'd1);
      check("t1_gap2", 64'(beat_cyc[2] - beat_cyc[1]), 64'd2);
      check("t1_gap3", 64'(beat_cyc[3] - beat_cyc[2]), 64'd1);
      check("t1_done_lat", 64'(done_cyc[0] - beat_cyc[3]), 64'd1);
    end

    // 2: two channels interleave in pairs
    do_reset();
    data_rx_ready_i = 1'b1;
    ch_valid_i      = 4'b0101;
    push_beats(0, 0, 2); push_beats(2, 0, 2);
    push_beats(0, 2, 2); push_beats(2, 2, 2);
    set_len(0, 4); set_len(2, 4);
    pulse_start(4'b0101);
    wait_drain("t2");
    check("t2_done0", 64'(done_cnt[0]), 64'd1);
    check("t2_done2", 64'(done_cnt[2]), 64'd1);

    // 3: L2 back-pressure mid-pair holds the grant
    do_reset();
    data_rx_ready_i = 1'b1;
    ch_valid_i      = 4'b0010;
    push_beats(1, 0, 4);
    set_len(1, 4);
    pulse_start(4'b0010);
    tick();
    tick();
    data_rx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("t3_hold_valid", 64'(data_rx_valid_o), 64'd1);
      check("t3_hold_chan",  64'(data_rx_chan_o),  64'd1);
      check("t3_hold_ready", 64'(ch_ready_o),      64'd0);
      tick();
    end
    data_rx_ready_i = 1'b1;
    wait_drain("t3");
    check("t3_done1", 64'(done_cnt[1]), 64'd1);
`ifdef UDMA_RX_ARB_STATS_EN
    check("t3_stall1", 64'(ch_stall_cnt_o[16 +: 16]), 64'd3);
`else
    check("t3_stall1", 64'(ch_stall_cnt_o[16 +: 16]), 64'd0);
`endif

    // 4: clear while locked releases the grant, with no done pulse
    do_reset();
    data_rx_ready_i = 1'b1;
    ch_valid_i      = 4'b0011;
    push_beats(0, 0, 2);
    push_beats(1, 0, 2);
    set_len(0, 6); set_len(1, 2);
    pulse_start(4'b0011);
    tick();
    tick();
    cfg_clr_i = 4'b0001;
    tick();
    cfg_clr_i = '0;
    #2;
    check("t4_busy0", 64'(ch_busy_o[0]), 64'd0);
    check("t4_release", 64'(data_rx_valid_o), 64'd0);
    wait_drain("t4");
    check("t4_done0", 64'(done_cnt[0]), 64'd0);
    check("t4_done1", 64'(done_cnt[1]), 64'd1);

    // 5: zero-length start; a start while busy is ignored
    do_reset();
    data_rx_ready_i = 1'b1;
    ch_valid_i      = 4'b1000;
    set_len(3, 0);
    pulse_start(4'b1000);
    #2;
    check("t5_done_pulse", 64'(ch_done_o[3]), 64'd1);
    check("t5_busy_len0",  64'(ch_busy_o[3]), 64'd0);
    check("t5_no_grant",   64'(data_rx_valid_o), 64'd0);
    tick();
    check("t5_done_one",   64'(ch_done_o[3]), 64'd0);
    check("t5_no_grant2",  64'(data_rx_valid_o), 64'd0);
    ch_valid_i = '0;
    set_len(3, 8);
    pulse_start(4'b1000);
    check("t5_busy", 64'(ch_busy_o[3]), 64'd1);
    tick();
    set_len(3, 2);
    pulse_start(4'b1000);
    check("t5_busy_kept", 64'(ch_busy_o[3]), 64'd1);
    push_beats(3, 0, 8);
    ch_valid_i = 4'b1000;
    wait_drain("t5");
    check("t5_nbeats", 64'(beat_cyc.size()), 64'd8);
    check("t5_done3",  64'(done_cnt[3]), 64'd2);

    // 6: reset mid-lock, after rr_ptr has moved away from 0
    do_reset();
    data_rx_ready_i = 1'b1;
    ch_valid_i      = 4'b1101;
    push_beats(2, 0, 2);
    set_len(2, 2);
    pulse_start(4'b0100);
    wait_drain("t6a");
    data_rx_ready_i = 1'b0;
    set_len(2, 4);
    pulse_start(4'b0100);
    tick();
    check("t6_locked_valid", 64'(data_rx_valid_o), 64'd1);
    check("t6_locked_chan",  64'(data_rx_chan_o),  64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    do_reset();
    data_rx_ready_i = 1'b1;
    ch_valid_i      = 4'b1001;
    push_beats(0, 0, 2);
    push_beats(3, 0, 2);
    set_len(0, 2); set_len(3, 2);
    pulse_start(4'b1001);
    wait_drain("t6");
    check("t6_done0", 64'(done_cnt[0]), 64'd1);
    check("t6_done3", 64'(done_cnt[3]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
